ptw_mem_arbiter: RTL and testbench
==================================

Name: ptw_mem_arbiter

Overview:
- Sits between the instruction TLB and data TLB page-table walkers and the shared AXI read master.
- Accepts single-cycle PTE read requests from each walker, holds them pending, and arbitrates round-robin.
- Issues one AXI read at a time: one address handshake, then one data beat.
- Returns the 64-bit PTE to the requesting walker as a one-cycle valid pulse, with an error flag.

Parameters:
- ADDR_WIDTH, 64, physical PTE address width.
- DATA_WIDTH, 64, PTE width.
- TIMEOUT_CYCLES, 1024, cycles to wait for the data beat before forcing an error response (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- I_REQ_VALID  in  1  single-cycle request pulse from the instruction TLB.
- I_REQ_ADDR  in  ADDR_WIDTH  PTE address, sampled when I_REQ_VALID=1.
- I_RESP_VALID  out  1  one-cycle response pulse to the instruction TLB.
- I_RESP_DATA  out  DATA_WIDTH  PTE returned to the instruction TLB.
- I_RESP_ERR  out  1  response error; qualified by I_RESP_VALID.
- D_REQ_VALID / D_REQ_ADDR / D_RESP_VALID / D_RESP_DATA / D_RESP_ERR  same as the I_ ports, for the data TLB.
- M_ARVALID  out  1  AXI read-address valid.
- M_ARREADY  in  1  AXI read-address ready.
- M_ARADDR  out  ADDR_WIDTH  AXI read address.
- M_RVALID  in  1  AXI read-data valid.
- M_RREADY  out  1  AXI read-data ready.
- M_RDATA  in  DATA_WIDTH  AXI read data.
- M_RRESP  in  2  AXI read response; 0 = OKAY.
- OVERRUN  out  1  sticky flag: a request arrived on a port that already had one pending or in service. Cleared only by reset.

Behaviour:
- Clock and reset: one clock, CLK; RST is synchronous and active-high.
- Reset values: all outputs 0, except M_RREADY=1. Pending flags cleared, state IDLE, last_grant=D (so I wins the first tie), drain flag 0.
- Request capture: when a port's REQ_VALID=1 and that port is neither pending nor in service, set its pending flag and latch its address at the clock edge.
  - If the port is already pending or in service, the new request is dropped, the first request is kept, and OVERRUN is set.
  - Simultaneous I and D pulses are both captured.
- State machine: IDLE, ADDR, DATA, RESP.
  - IDLE: if any port is pending, grant it. If both are pending, grant the port that is not last_grant. Update last_grant, clear the winner's pending flag, load M_ARADDR, go to ADDR.
  - ADDR: M_ARVALID=1. M_ARADDR is held stable until M_ARVALID && M_ARREADY, then go to DATA.
  - DATA: M_RREADY=1. On M_RVALID, register M_RDATA and set err = (M_RRESP != 0), then go to RESP.
  - RESP: pulse the owner's RESP_VALID for exactly one cycle with the registered RESP_DATA and RESP_ERR, then return to IDLE.
- Latency: request pulse in cycle 0 → pending at edge 0 → grant in cycle 1 → M_ARVALID high from cycle 2. With ARREADY and RVALID each one cycle late, RESP_VALID rises in cycle 5.
- Minimum issue gap: one IDLE cycle between consecutive grants.
- RESP_DATA and RESP_ERR hold their last value when RESP_VALID=0. The non-owner's RESP_VALID stays 0.
- Stray beat drain: M_RREADY=1 in IDLE. Any R beat accepted in IDLE, or while the drain flag is set, is discarded and produces no response.
- Reset mid-transaction: the outstanding read is abandoned and all pending requests are lost. A late R beat after reset is drained as above.
- Widths: addresses pass through unmodified. Bits [2:0] of the address are expected to be 0 (8-byte PTE); they are not checked.

Optional Feature:
- Macro: PTW_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to DATA and increments each cycle in DATA.
  - When it reaches TIMEOUT_CYCLES-1 without M_RVALID, go to RESP with err=1 and data=0, and set the drain flag.
  - The drain flag discards the next accepted R beat, then clears.
  - While the drain flag is set, IDLE does not grant.
- Undefined: no counter and no drain flag; DATA waits indefinitely for M_RVALID.

Decomposition:
- Shared package: state encoding (IDLE/ADDR/DATA/RESP), port-ID constants PORT_I=0 and PORT_D=1, AXI response constant RESP_OKAY=2'b00.
- One sub-module, ptw_req_slot, instantiated twice (I and D). It holds the pending flag, the latched address and the overrun detection, and exposes pending/addr/clear.

Test Plan:
- Single I request, addr 0x8000_1008, ARREADY and RVALID one cycle late, RDATA=0x0000_0000_2000_00CF, RRESP=0 → M_ARADDR=0x8000_1008; I_RESP_VALID one pulse in cycle 5 with that data; I_RESP_ERR=0; D_RESP_VALID stays 0.
- I and D pulses in the same cycle (0x1000, 0x2000), repeated twice → grants in order I, D, I, D; each response is routed to the correct port.
- ARREADY held low for 10 cycles → M_ARVALID=1 and M_ARADDR stable all 10 cycles; exactly one address handshake.
- RRESP=2'b10 (SLVERR) → D_RESP_VALID pulse with D_RESP_ERR=1.
- Second I pulse while the first is in DATA → OVERRUN=1; only one I response; RST asserted mid-DATA → all outputs at reset values next cycle, and a late R beat produces no response.
- With PTW_TIMEOUT_EN and TIMEOUT_CYCLES=16, no RVALID → error response after 16 DATA cycles; a late R beat is drained; a following request completes normally.

Source files
------------

// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared definitions for the page-table-walker memory arbiter: FSM states,
// walker port identifiers, AXI response code and the round-robin pick rule.
package ptw_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t   PORT_I    = 1'b0;
  localparam port_id_t   PORT_D    = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // On a tie the port that did not win last time is chosen.
  function automatic port_id_t rr_pick(input logic pend_i, input logic pend_d,
                                       input port_id_t last_grant);
    if (pend_i && pend_d) return (last_grant == PORT_I) ? PORT_D : PORT_I;
    return pend_d ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/ptw_req_slot.sv
// One-deep request holder for a single walker: pending flag, latched PTE
// address and a sticky overrun flag for requests that arrive while occupied.
module ptw_req_slot
  import ptw_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic                  i_busy,
  input  logic                  i_clear,
  output logic                  o_pending,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_overrun
);

  logic                  r_pending;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_overrun;
  logic                  w_accept;

  // A port that is waiting or being served keeps its first request.
  assign w_accept = i_req_valid && !r_pending && !i_busy;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= 1'b0;
      r_addr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pending <= 1'b1;
        r_addr    <= i_req_addr;
      end else if (i_clear) begin
        r_pending <= 1'b0;
      end
      if (i_req_valid && !w_accept) r_overrun <= 1'b1;
    end
  end

  assign o_pending = r_pending;
  assign o_addr    = r_addr;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Round-robin arbiter from the I/D TLB page-table walkers onto one AXI read
// master, one single-beat read in flight. Optional macro: PTW_TIMEOUT_EN.
module ptw_mem_arbiter
  import ptw_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_i_req_addr,
  output logic                  o_i_resp_valid,
  output logic [DATA_WIDTH-1:0] o_i_resp_data,
  output logic                  o_i_resp_err,
  input  logic                  i_d_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_d_req_addr,
  output logic                  o_d_resp_valid,
  output logic [DATA_WIDTH-1:0] o_d_resp_data,
  output logic                  o_d_resp_err,
  output logic                  o_m_arvalid,
  input  logic                  i_m_arready,
  output logic [ADDR_WIDTH-1:0] o_m_araddr,
  input  logic                  i_m_rvalid,
  output logic                  o_m_rready,
  input  logic [DATA_WIDTH-1:0] i_m_rdata,
  input  logic [1:0]            i_m_rresp,
  output logic                  o_overrun
);

  state_t                r_state, w_next_state;
  port_id_t              r_owner, r_last_grant, w_grant_port;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [DATA_WIDTH-1:0] r_i_data, r_d_data;
  logic                  r_i_err, r_d_err;
  logic                  w_grant_valid, w_beat_take, w_timeout;
  logic                  w_drain, w_tmo_hit;
  logic                  w_i_pending, w_d_pending, w_i_overrun, w_d_overrun;
  logic                  w_i_busy, w_d_busy;
  logic [ADDR_WIDTH-1:0] w_i_addr, w_d_addr;

  assign w_i_busy = (r_state != ST_IDLE) && (r_owner == PORT_I);
  assign w_d_busy = (r_state != ST_IDLE) && (r_owner == PORT_D);

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_i (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_i_req_valid),
    .i_req_addr  (i_i_req_addr),
    .i_busy      (w_i_busy),
    .i_clear     (w_grant_valid && (w_grant_port == PORT_I)),
    .o_pending   (w_i_pending),
    .o_addr      (w_i_addr),
    .o_overrun   (w_i_overrun)
  );

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_d (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_d_req_valid),
    .i_req_addr  (i_d_req_addr),
    .i_busy      (w_d_busy),
    .i_clear     (w_grant_valid && (w_grant_port == PORT_D)),
    .o_pending   (w_d_pending),
    .o_addr      (w_d_addr),
    .o_overrun   (w_d_overrun)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_grant_valid = 1'b0;
    w_grant_port  = PORT_I;
    w_beat_take   = 1'b0;
    w_timeout     = 1'b0;
    o_m_arvalid   = 1'b0;
    o_m_rready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_m_rready = 1'b1;
        if (!w_drain && (w_i_pending || w_d_pending)) begin
          w_grant_valid = 1'b1;
          w_grant_port  = rr_pick(w_i_pending, w_d_pending, r_last_grant);
          w_next_state  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        o_m_arvalid = 1'b1;
        if (i_m_arready) w_next_state = ST_DATA;
      end
      ST_DATA: begin
        o_m_rready = 1'b1;
        if (i_m_rvalid) begin
          w_beat_take  = 1'b1;
          w_next_state = ST_RESP;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner      <= PORT_I;
      r_last_grant <= PORT_D;
      r_araddr     <= '0;
      r_i_data     <= '0;
      r_d_data     <= '0;
      r_i_err      <= 1'b0;
      r_d_err      <= 1'b0;
    end else begin
      if (w_grant_valid) begin
        r_owner      <= w_grant_port;
        r_last_grant <= w_grant_port;
        r_araddr     <= (w_grant_port == PORT_I) ? w_i_addr : w_d_addr;
      end
      // Response registers are per port so each walker's outputs hold.
      if (w_beat_take || w_timeout) begin
        if (r_owner == PORT_I) begin
          r_i_data <= w_timeout ? '0 : i_m_rdata;
          r_i_err  <= w_timeout || (i_m_rresp != RESP_OKAY);
        end else begin
          r_d_data <= w_timeout ? '0 : i_m_rdata;
          r_d_err  <= w_timeout || (i_m_rresp != RESP_OKAY);
        end
      end
    end
  end

`ifdef PTW_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_drain;

  // The drain flag swallows the beat that a timed-out read still owes us.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
      r_drain   <= 1'b0;
    end else begin
      if (r_state == ST_ADDR && i_m_arready) r_tmo_cnt <= '0;
      else if (r_state == ST_DATA)           r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_timeout)                                     r_drain <= 1'b1;
      else if (r_drain && i_m_rvalid && o_m_rready) r_drain <= 1'b0;
    end
  end

  assign w_drain   = r_drain;
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_drain      = 1'b0;
  assign w_tmo_hit    = 1'b0;
`endif

  assign o_m_araddr     = r_araddr;
  assign o_i_resp_valid = (r_state == ST_RESP) && (r_owner == PORT_I);
  assign o_d_resp_valid = (r_state == ST_RESP) && (r_owner == PORT_D);
  assign o_i_resp_data  = r_i_data;
  assign o_d_resp_data  = r_d_data;
  assign o_i_resp_err   = r_i_err;
  assign o_d_resp_err   = r_d_err;
  assign o_overrun      = w_i_overrun | w_d_overrun;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_ptw_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [63:0] i_addr, d_addr;
  logic        i_rv, d_rv, i_err, d_err;
  logic [63:0] i_data, d_data;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [63:0] m_araddr, m_rdata;
  logic [1:0]  m_rresp;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  ptw_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_i_req_valid  (i_req),
    .i_i_req_addr   (i_addr),
    .o_i_resp_valid (i_rv),
    .o_i_resp_data  (i_data),
    .o_i_resp_err   (i_err),
    .i_d_req_valid  (d_req),
    .i_d_req_addr   (d_addr),
    .o_d_resp_valid (d_rv),
    .o_d_resp_data  (d_data),
    .o_d_resp_err   (d_err),
    .o_m_arvalid    (m_arvalid),
    .i_m_arready    (m_arready),
    .o_m_araddr     (m_araddr),
    .i_m_rvalid     (m_rvalid),
    .o_m_rready     (m_rready),
    .i_m_rdata      (m_rdata),
    .i_m_rresp      (m_rresp),
    .o_overrun      (overrun)
  );

  typedef struct {
    bit          port;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] pte_of(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0000_0000_0000_00CF;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    i_req = 0; d_req = 0; i_addr = '0; d_addr = '0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input bit do_i, input logic [63:0] ai, input bit do_d, input logic [63:0] ad);
    i_req = do_i; i_addr = ai;
    d_req = do_d; d_addr = ad;
    tick();
    i_req = 0; d_req = 0;
  endtask

  // Plays the AXI slave for one read and checks the routed response.
  task automatic serve(input string nm, input bit port, input logic [63:0] addr,
                       input int ar_delay, input logic [63:0] rdata,
                       input logic [1:0] rresp, input bit exp_err, output int resp_cyc);
    int n = 0;
    while (!m_arvalid && n < 20) begin
      tick();
      n++;
    end
    check({nm, " arvalid"}, m_arvalid, 1);
    check({nm, " araddr"}, m_araddr, addr);
    for (int k = 0; k < ar_delay; k++) begin
      m_arready = 0;
      tick();
      check({nm, " arvalid held"}, m_arvalid, 1);
      check({nm, " araddr held"}, m_araddr, addr);
    end
    m_arready = 1;
    tick();
    m_arready = 0;
    check({nm, " single handshake"}, m_arvalid, 0);
    check({nm, " rready in data"}, m_rready, 1);
    m_rvalid = 1; m_rdata = rdata; m_rresp = rresp;
    tick();
    m_rvalid = 0;
    resp_cyc = cyc;
    check({nm, " own resp_valid"}, port ? d_rv : i_rv, 1);
    check({nm, " other resp_valid"}, port ? i_rv : d_rv, 0);
    check({nm, " resp_data"}, port ? d_data : i_data, rdata);
    check({nm, " resp_err"}, port ? d_err : i_err, exp_err);
    tick();
    check({nm, " one-cycle pulse"}, port ? d_rv : i_rv, 0);
  endtask

  task automatic rand_test();
    bit          busy[2], issued[2], busy_before[2];
    logic [63:0] paddr[2];
    int          acc[2];
    bit          exp_ovr, prev_arv, beat_pend, last, p, ci, cd, legal, rv;
    int          beat_dly;
    logic [63:0] beat_addr, a;
    apply_reset();
    busy = '{0, 0}; issued = '{0, 0}; acc = '{0, 0};
    exp_ovr = 0; prev_arv = 0; beat_pend = 0; beat_dly = 0; last = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      check("rand overrun", overrun, exp_ovr);
      if (m_arvalid && !prev_arv) begin
        p  = m_araddr[63];
        ci = busy[0] && !issued[0] && (acc[0] <= c - 2);
        cd = busy[1] && !issued[1] && (acc[1] <= c - 2);
        legal = (ci && cd) ? (p != last) : (p ? cd : ci);
        check("rand grant legal", legal, 1);
        check("rand araddr", m_araddr, paddr[p]);
        issued[p] = 1;
        last = p;
      end
      prev_arv = m_arvalid;
      m_rvalid = 0;
      if (beat_pend) begin
        if (beat_dly == 0) begin
          m_rvalid = 1;
          m_rdata  = pte_of(beat_addr);
          m_rresp  = beat_addr[5:4];
          if (m_rready) beat_pend = 0;
        end else begin
          beat_dly--;
        end
      end
      m_arready = 1'($urandom_range(0, 1));
      if (m_arvalid && m_arready) begin
        beat_pend = 1;
        beat_dly  = $urandom_range(0, 5);
        beat_addr = m_araddr;
      end
      busy_before = busy;
      for (int q = 0; q < 2; q++) begin
        rv = q ? d_rv : i_rv;
        if (rv) begin
          check("rand resp owner", busy[q] && issued[q], 1);
          check("rand resp data", q ? d_data : i_data, pte_of(paddr[q]));
          check("rand resp err", q ? d_err : i_err, paddr[q][5:4] != 2'b00);
          busy[q] = 0;
          issued[q] = 0;
        end
      end
      i_req = 0; d_req = 0;
      for (int q = 0; q < 2; q++) begin
        if (c < 2800 && $urandom_range(0, 3) == 0) begin
          a = {1'(q), 31'($urandom), $urandom};
          a[2:0] = 3'b000;
          if (q == 0) begin i_req = 1; i_addr = a; end
          else begin d_req = 1; d_addr = a; end
          if (busy_before[q]) begin
            exp_ovr = 1;
          end else begin
            busy[q] = 1; issued[q] = 0; acc[q] = c; paddr[q] = a;
          end
        end
      end
      tick();
    end
    i_req = 0; d_req = 0; m_rvalid = 0; m_arready = 0;
    check("rand all served", {62'd0, busy[1], busy[0]}, 0);
  endtask

  initial begin
    int t0, rc, n, cnt;
    vecs[0] = '{1'b0, 64'h0000_0000_8000_1008, 64'h0000_0000_2000_00CF, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 64'h0000_0004_1234_5670, 64'hDEAD_BEEF_0000_0001, 2'b10, 1'b1};
    vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1};
    vecs[3] = '{1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 2'b01, 1'b1};
    vecs[4] = '{1'b1, 64'h0000_0000_0000_0FF8, 64'h1234_5678_9ABC_DEF0, 2'b00, 1'b0};

    apply_reset();
    check("reset arvalid", m_arvalid, 0);
    check("reset rready", m_rready, 1);
    check("reset araddr", m_araddr, 0);
    check("reset resp_valid", {62'd0, i_rv, d_rv}, 0);
    check("reset resp_data", i_data | d_data, 0);
    check("reset overrun", overrun, 0);

    foreach (vecs[i]) begin
      t0 = cyc;
      pulse(!vecs[i].port, vecs[i].addr, vecs[i].port, vecs[i].addr);
      check("vec idle before grant", m_arvalid, 0);
      tick();
      serve("vec", vecs[i].port, vecs[i].addr, 1, vecs[i].rdata, vecs[i].rresp,
            vecs[i].exp_err, rc);
      check("vec latency", rc - t0, 5);
    end

    for (int r = 0; r < 2; r++) begin
      pulse(1, 64'h1000, 1, 64'h2000);
      serve("tie first I", 1'b0, 64'h1000, 0, 64'hAAAA_0000_0000_1000, 2'b00, 0, rc);
      serve("tie then D", 1'b1, 64'h2000, 0, 64'hBBBB_0000_0000_2000, 2'b00, 0, rc);
    end

    pulse(1, 64'h9000, 0, 64'h0);
    serve("ar hold", 1'b0, 64'h9000, 10, 64'h0000_0000_0000_9001, 2'b00, 0, rc);

    pulse(1, 64'h3000, 0, 64'h0);
    tick();
    m_arready = 1;
    tick();
    m_arready = 0;
    pulse(1, 64'h4000, 0, 64'h0);
    check("overrun set", overrun, 1);
    m_rvalid = 1; m_rdata = 64'h3333; m_rresp = 2'b00;
    tick();
    m_rvalid = 0;
    check("overrun first resp", i_rv, 1);
    check("overrun first data", i_data, 64'h3333);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      cnt += int'(i_rv) + int'(m_arvalid);
    end
    check("overrun dropped request", cnt, 0);

    pulse(0, 64'h0, 1, 64'h5000);
    tick();
    m_arready = 1;
    tick();
    m_arready = 0;
    check("mid-data rready", m_rready, 1);
    rst = 1;
    tick();
    rst = 0;
    check("rst arvalid", m_arvalid, 0);
    check("rst rready", m_rready, 1);
    check("rst araddr", m_araddr, 0);
    check("rst resp_valid", {62'd0, i_rv, d_rv}, 0);
    check("rst resp_data", i_data | d_data, 0);
    check("rst resp_err", {62'd0, i_err, d_err}, 0);
    check("rst overrun", overrun, 0);
    m_rvalid = 1; m_rdata = 64'h5555; m_rresp = 2'b00;
    tick();
    m_rvalid = 0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cnt += int'(i_rv) + int'(d_rv) + int'(m_arvalid);
      tick();
    end
    check("late beat discarded", cnt, 0);

`ifdef PTW_TIMEOUT_EN
    apply_reset();
    pulse(1, 64'h6000, 0, 64'h0);
    tick();
    m_arready = 1;
    tick();
    m_arready = 0;
    n = 0;
    while (m_rready && n < 40) begin
      n++;
      tick();
    end
    check("timeout data cycles", n, 16);
    check("timeout resp_valid", i_rv, 1);
    check("timeout resp_err", i_err, 1);
    check("timeout resp_data", i_data, 0);
    tick();
    pulse(0, 64'h0, 1, 64'h7000);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cnt += int'(m_arvalid);
      tick();
    end
    check("drain blocks grant", cnt, 0);
    m_rvalid = 1; m_rdata = 64'h6666; m_rresp = 2'b00;
    tick();
    m_rvalid = 0;
    check("drained beat no resp", {62'd0, i_rv, d_rv}, 0);
    serve("after drain", 1'b1, 64'h7000, 0, 64'h7777, 2'b00, 0, rc);
`endif

    rand_test();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
